// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Multi-cycle instruction sequencer. Walks IDLE -> FETCH -> EXEC
//            -> WB, fetching one instruction word per pass, strobing the
//            datapath execute and writeback phases, advancing the program
//            counter (sequential or redirected) and counting retired
//            instructions. A halt request is honoured only at the WB
//            boundary; start resumes from HALT at the current pc.
//
//            Optional build macro FETCH_SEQ_MISALIGN_TRAP_EN: a redirect to a
//            target with non-zero low address bits traps to HALT from EXEC,
//            sets the sticky err flag and skips writeback. Without the macro
//            the target is force-aligned to a 4-byte boundary and err is 0.
//
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            start, halt_req   begin/resume sequencing, stop at boundary
//            imem_req/addr     fetch request and address (== pc)
//            imem_ack/rdata    fetch completion and instruction word
//            instruction       latched instruction to the datapath
//            exec_en, wb_en    one-cycle execute / writeback strobes
//            redirect(_pc)     branch/jump taken and target, sampled in EXEC
//            pc                current program counter
//            busy, halted      status: FETCH/EXEC/WB, HALT
//            err               sticky misaligned-target flag
//            retired           completed-instruction counter (wraps)
//
// Revision : 1.0  initial release
// ============================================================================
module fetch_seq #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    output logic             imem_req,
    output logic [63:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic             exec_en,
    output logic             wb_en,
    input  logic             redirect,
    input  logic [63:0]      redirect_pc,
    output logic [63:0]      pc,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state,    w_state_nxt;
    logic [63:0]      r_pc,       w_pc_nxt;
    logic [31:0]      r_instr,    w_instr_nxt;
    logic [CNT_W-1:0] r_retired,  w_retired_nxt;
    logic             r_err,      w_err_nxt;
    logic             r_redir,    w_redir_nxt;
    logic [63:0]      r_redir_pc, w_redir_pc_nxt;
    logic             w_trap;

    // Only a redirect taken in EXEC can trap; the low target bits decide it.
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    assign w_trap = redirect && (redirect_pc[1:0] != 2'b00);
`else
    logic w_unused_lsbs;
    assign w_trap        = 1'b0;
    assign w_unused_lsbs = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_retired  <= '0;
            r_err      <= 1'b0;
            r_redir    <= 1'b0;
            r_redir_pc <= 64'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_retired  <= w_retired_nxt;
            r_err      <= w_err_nxt;
            r_redir    <= w_redir_nxt;
            r_redir_pc <= w_redir_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_retired_nxt  = r_retired;
        w_err_nxt      = r_err;
        w_redir_nxt    = r_redir;
        w_redir_pc_nxt = r_redir_pc;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_FETCH;
                    w_pc_nxt      = RESET_PC;
                    w_retired_nxt = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Target is stored word-aligned; a misaligned one only
                // survives to here when the trap is disabled.
                w_redir_nxt    = redirect;
                w_redir_pc_nxt = {redirect_pc[63:2], 2'b00};
                if (w_trap) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_pc_nxt      = r_redir ? r_redir_pc : (r_pc + 64'd4);
                w_retired_nxt = r_retired + c_cnt_one;
                w_state_nxt   = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status and strobes decode straight from the state register so that an
    // asynchronous reset clears them in the same cycle.
    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign exec_en     = (r_state == S_EXEC);
    assign wb_en       = (r_state == S_WB);
    assign pc          = r_pc;
    assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                         (r_state == S_WB);
    assign halted      = (r_state == S_HALT);
    assign err         = r_err;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Self-checking bench for fetch_seq. Directed steps followed by
//            randomized instructions, compared against a per-instruction
//            reference model (pc, retired count, err, latched word).
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_seq;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          CNT_W    = 6;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, halt_req, imem_ack, redirect;
    logic [31:0]      imem_rdata;
    logic [63:0]      redirect_pc;
    logic             imem_req, exec_en, wb_en, busy, halted, err;
    logic [63:0]      imem_addr, pc;
    logic [31:0]      instruction;
    logic [CNT_W-1:0] retired;

    fetch_seq #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction),
        .exec_en(exec_en), .wb_en(wb_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [63:0]      m_pc;
    logic [CNT_W-1:0] m_ret;
    logic             m_err;
    logic [31:0]      m_instr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic resume_from_halt();
        for (int i = 0; i < 2; i++) begin
            start    = 1'b0;
            imem_ack = 1'($urandom);
            halt_req = 1'($urandom);
            tick();
            chk("halt_hold", {62'b0, halted, busy}, 64'b10);
            chk("halt_pc", pc, m_pc);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, m_pc);
        chk("resume_ret", retired, m_ret);
        chk("resume_err", err, m_err);
    endtask

    // Runs one instruction starting with the DUT in FETCH.
    task automatic run_instr(input int d, input logic [31:0] data, input logic redir,
                             input logic [63:0] rp, input logic hreq);
        bit trap;
        for (int k = 0; k <= d; k++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_busy", {61'b0, busy, exec_en, wb_en}, 64'b100);
            chk("fetch_instr_hold", instruction, m_instr);
            imem_ack    = (k == d);
            imem_rdata  = (k == d) ? data : $urandom;
            redirect    = 1'($urandom);
            redirect_pc = rnd64();
            halt_req    = 1'($urandom);
            start       = 1'($urandom);
            tick();
        end
        m_instr = data;
        chk("exec_strobe", {61'b0, exec_en, wb_en, imem_req}, 64'b100);
        chk("exec_instr", instruction, m_instr);
        imem_ack    = 1'($urandom);
        imem_rdata  = $urandom;
        redirect    = redir;
        redirect_pc = rp;
        halt_req    = 1'($urandom);
        start       = 1'($urandom);
        tick();
        trap = TRAP && redir && (rp[1:0] != 2'b00);
        if (trap) begin
            m_err = 1'b1;
            chk("trap_halted", {62'b0, halted, wb_en}, 64'b10);
            chk("trap_err", err, 1);
            chk("trap_pc", pc, m_pc);
            chk("trap_ret", retired, m_ret);
            resume_from_halt();
        end else begin
            chk("wb_strobe", {61'b0, wb_en, exec_en, imem_req}, 64'b100);
            chk("wb_instr", instruction, m_instr);
            imem_ack    = 1'($urandom);
            imem_rdata  = $urandom;
            redirect    = 1'($urandom);
            redirect_pc = rnd64();
            halt_req    = hreq;
            start       = 1'($urandom);
            tick();
            m_pc  = redir ? {rp[63:2], 2'b00} : m_pc + 64'd4;
            m_ret = m_ret + 1'b1;
            chk("next_pc", pc, m_pc);
            chk("retired", retired, m_ret);
            chk("err", err, m_err);
            if (hreq) begin
                chk("halt_state", {62'b0, halted, busy}, 64'b10);
                resume_from_halt();
            end else begin
                chk("next_fetch", {62'b0, imem_req, halted}, 64'b10);
            end
        end
        imem_ack = 1'b0;
        start    = 1'b0;
        halt_req = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_addr"}, imem_addr, RESET_PC);
        chk({tag, "_instr"}, instruction, 0);
        chk({tag, "_ret"}, retired, 0);
        chk({tag, "_flags"}, {58'b0, imem_req, exec_en, wb_en, busy, halted, err}, 0);
    endtask

    initial begin
        logic [63:0] rp;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 64'h0;
        m_pc = RESET_PC; m_ret = '0; m_err = 1'b0; m_instr = 32'h0;

        // Reset values, then IDLE ignores ack and halt_req
        tick(); tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        halt_req = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
        tick();
        chk_reset_outputs("idle");
        halt_req = 1'b0; imem_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_fetch", {62'b0, imem_req, busy}, 64'b11);

        // Immediate ack, sequential pc 0 -> 4
        run_instr(0, 32'h00500093, 1'b0, 64'h0, 1'b0);
        chk("pc_after_first", pc, 64'h4);
        // Four-cycle delayed ack, pc 4 -> 8
        run_instr(4, 32'h12345678, 1'b0, 64'h0, 1'b0);
        // Halt honoured at WB of instr at pc=8, resume at 12
        run_instr(1, 32'hcafef00d, 1'b0, 64'h0, 1'b1);
        chk("resume_at_12", imem_addr, 64'hc);
        // Redirect to 0x100
        run_instr(0, 32'h0000006f, 1'b1, 64'h100, 1'b0);
        chk("redirect_addr", imem_addr, 64'h100);
        // Misaligned target: trap or force-align
        run_instr(2, 32'h0000006f, 1'b1, 64'h102, 1'b0);
        chk("misalign_pc", pc, TRAP ? 64'h100 : 64'h100);
        chk("misalign_err", err, TRAP ? 1 : 0);

        // Randomized instructions (retired wraps at 2^CNT_W)
        for (int n = 0; n < 90; n++) begin
            rp = rnd64();
            if ($urandom_range(0, 7) != 0) rp[1:0] = 2'b00;
            run_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) == 0),
                      rp, 1'($urandom_range(0, 5) == 0));
        end

        // Reset mid-FETCH at pc=0x20, late ack afterwards is ignored
        run_instr(0, 32'h00000013, 1'b1, 64'h20, 1'b0);
        chk("pre_reset_addr", imem_addr, 64'h20);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h5555aaaa;
        tick();
        chk_reset_outputs("late_ack");
        imem_ack = 1'b0;
        tick();
        chk_reset_outputs("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded at reset and on start from IDLE.
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin (IDLE) or resume (HALT) sequencing.
REQ-006 halt_req  input  1  stop at next instruction boundary.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  64  fetch address, equals pc.
REQ-009 imem_ack  input  1  fetch complete; imem_rdata valid.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instruction  output  32  latched instruction driven to datapath.
REQ-012 exec_en  output  1  one-cycle datapath execute strobe.
REQ-013 wb_en  output  1  one-cycle register-file writeback strobe.
REQ-014 redirect  input  1  datapath branch/jump taken, sampled in EXEC only.
REQ-015 redirect_pc  input  64  branch/jump target, sampled with redirect.
REQ-016 pc  output  64  current program counter.
REQ-017 busy  output  1  high in FETCH, EXEC, WB.
REQ-018 halted  output  1  high in HALT.
REQ-019 err  output  1  sticky misaligned-target flag.
REQ-020 retired  output  CNT_W  count of completed instructions.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, EXEC, WB, HALT; transitions only on clk rising edge.
REQ-022 IDLE: start=1 -> FETCH with pc=RESET_PC, retired=0; otherwise remain; halt_req ignored.
REQ-023 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack=1; on ack latch imem_rdata into instruction, -> EXEC.
REQ-024 imem_ack outside FETCH SHALL be ignored; instruction SHALL change only on a FETCH ack.
REQ-025 EXEC: exec_en=1 for exactly one cycle; sample redirect and redirect_pc; -> WB.
REQ-026 WB: wb_en=1 one cycle; pc <= sampled redirect ? redirect_pc : pc+4 (mod 2^64); retired <= retired+1 (wraps at 2^CNT_W).
REQ-027 WB exit: halt_req=1 -> HALT, else -> FETCH.
REQ-028 halt_req asserted in FETCH/EXEC SHALL NOT abort the instruction; only its level in WB is honored.
REQ-029 HALT: start=1 -> FETCH resuming at current pc, retired preserved, err preserved.
REQ-030 Throughput SHALL be 3 cycles/instruction when imem_ack is returned in the first FETCH cycle; each extra wait cycle adds one.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE regardless of state, including mid-fetch with imem_req high.
REQ-033 Reset values: pc=RESET_PC, instruction=0, retired=0, err=0, imem_req=exec_en=wb_en=busy=halted=0, imem_addr=RESET_PC.
REQ-034 After rst_n deasserts, an ack from a pre-reset fetch SHALL have no effect (state is IDLE).

Configuration
REQ-035 Macro FETCH_SEQ_MISALIGN_TRAP_EN defined: sampled redirect with redirect_pc[1:0]!=0 in EXEC SHALL go to HALT instead of WB, set err=1, suppress wb_en, leave pc and retired unchanged.
REQ-036 Macro undefined: pc SHALL load {redirect_pc[63:2],2'b00} in WB; err SHALL be tied 0.

Verification
REQ-037 Reset, start, imem_ack immediate, rdata=32'h00500093, no redirect -> exec_en 1 cycle later, wb_en next, pc 0->4, retired=1, 3-cycle cadence.
REQ-038 imem_ack delayed 4 cycles in FETCH -> imem_req/imem_addr stable 5 cycles, single exec_en, retired increments once.
REQ-039 redirect=1, redirect_pc=64'h100 in EXEC -> next imem_addr=64'h100; redirect=1 in FETCH only -> ignored, pc+4.
REQ-040 halt_req raised during EXEC of instr at pc=8 -> wb_en, pc=12, HALT, halted=1; start -> FETCH at 12.
REQ-041 rst_n pulsed low mid-FETCH at pc=64'h20 -> IDLE same cycle, all outputs at REQ-033 values; late imem_ack ignored.
REQ-042 With FETCH_SEQ_MISALIGN_TRAP_EN, redirect_pc=64'h102 -> HALT, err=1, no wb_en, pc unchanged; without macro -> pc=64'h100, err=0.
